snoop_bcast: RTL and testbench
==============================

SNOOP_BCAST -- requirements
Module: snoop_bcast

Interface
REQ-001 SHALL have parameters snoop_req_t, snoop_resp_t, ac_chan_t, cr_chan_t, cd_chan_t; default logic; snoop bundle and channel types.
REQ-002 SHALL have parameter NoMstPorts, default 32'd2, number of snooped master ports, legal value >=2.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port slv_req_i, input, snoop_req_t: upstream AC, plus cr_ready and cd_ready.
REQ-006 SHALL have port slv_resp_o, output, snoop_resp_t: upstream ac_ready, merged CR, and forwarded CD.
REQ-007 SHALL have port mst_reqs_o, output, snoop_req_t[NoMstPorts]: per-port AC, cr_ready, cd_ready.
REQ-008 SHALL have port mst_resps_i, input, snoop_resp_t[NoMstPorts]: per-port ac_ready, CR, CD.

Function
REQ-009 SHALL implement FSM IDLE -> FORK -> COLLECT -> RESP -> (DATA | IDLE) -> IDLE, one snoop in flight.
REQ-010 IDLE SHALL assert slv ac_ready=1; on the AC handshake, register AC and go to FORK; all other outputs 0.
REQ-011 FORK SHALL drive registered AC with ac_valid=1 on each port whose acc_mask bit is 0; the bit sets on that port's handshake.
REQ-012 FORK SHALL move to COLLECT when acc_mask is all ones; no port's AC SHALL be re-issued after it is accepted.
REQ-013 COLLECT SHALL drive cr_ready=1 on each port not yet in cr_mask, capture cr_resp per port, and exit when cr_mask is all ones.
REQ-014 CR responses arriving while FORK is active SHALL be accepted; CR from all ports in one cycle SHALL complete COLLECT in that cycle.
REQ-015 Merged CR SHALL be the bitwise OR of all captured cr_resp (DataTransfer, Error, PassDirty, IsShared, WasUnique).
REQ-016 RESP SHALL hold slv cr_valid=1 with merged CR until slv cr_ready.
REQ-017 After the RESP handshake: if merged DataTransfer=0, go to IDLE; otherwise go to DATA.
REQ-018 Selected port SHALL be the lowest index with captured DataTransfer=1.
REQ-019 DATA SHALL pass the selected port's CD combinationally: slv cd_valid/cd equals the port's cd_valid/cd, and the port's cd_ready equals slv cd_ready.
REQ-020 DATA SHALL drain the other DataTransfer ports with cd_ready=1 and discard their data; ports without DataTransfer SHALL get cd_ready=0.
REQ-021 DATA SHALL exit to IDLE once every DataTransfer port has completed a beat with cd.last=1, in any order and including the same cycle.
REQ-022 Latency: AC upstream handshake in cycle n gives mst ac_valid in cycle n+1; merged CR is valid in the cycle after the last CR capture.
REQ-023 Once a valid is asserted on any interface, it and its payload SHALL be held until the handshake completes.

Reset
REQ-024 While rst_ni=0 at a clk_i edge: FSM to IDLE; acc_mask, cr_mask, captured CR and last-flags cleared; registered AC zeroed.
REQ-025 After reset all valid/ready outputs SHALL be 0 except slv ac_ready=1; reset mid-snoop SHALL abandon it with no further beats emitted.

Configuration
REQ-026 When macro SNOOP_BCAST_EXCL_EN is defined, input excl_i[NoMstPorts] SHALL be added and sampled with the upstream AC handshake.
REQ-027 Excluded ports SHALL get no AC, cr_ready or cd_ready; their acc_mask/cr_mask bits SHALL preset to 1 and their CR SHALL count as 0.
REQ-028 If all ports are excluded, FORK and COLLECT SHALL each take one cycle, and RESP SHALL return CR=0.
REQ-029 Without SNOOP_BCAST_EXCL_EN, excl_i SHALL NOT exist and all ports SHALL be snooped.

Structure
REQ-030 CR bit-index constants SHALL live in shared package ace_pkg; the FSM state enum SHALL be local to the module.
REQ-031 Selected-port lookup SHALL use common_cells lzc; no other sub-module.

Verification
REQ-032 4 ports, all accept AC the same cycle, CR={0,0,0x08,0} -> upstream CR=0x08 (IsShared), no DATA state, ready for next AC.
REQ-033 Port2 ac_ready 5 cycles late -> ports 0,1,3 see exactly one AC handshake each, port2 one handshake at its ready cycle.
REQ-034 Ports 1,3 CR=0x05 (DataTransfer+PassDirty), 4-beat CD -> upstream CR=0x05, upstream gets port1's 4 beats, port3's 4 beats drained, then IDLE.
REQ-035 Upstream cr_ready/cd_ready randomly stalled -> valid and payload stable through each stall, no beat lost or duplicated.
REQ-036 rst_ni=0 for 1 cycle during DATA beat 2 -> next cycle IDLE, slv ac_ready=1, all valids 0.
REQ-037 With SNOOP_BCAST_EXCL_EN, excl_i=4'b0010 -> port1 sees no AC and a port1 CR with DataTransfer is ignored; excl_i=4'b1111 -> CR=0 returned.

Source files
------------

// File: rtl/ace_pkg.sv
// Shared ACE snoop channel types and CR response bit positions.
package ace_pkg;

  localparam int unsigned CrW   = 5;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  localparam int unsigned CR_DT = 0;  // DataTransfer
  localparam int unsigned CR_ERR = 1; // Error
  localparam int unsigned CR_PD = 2;  // PassDirty
  localparam int unsigned CR_IS = 3;  // IsShared
  localparam int unsigned CR_WU = 4;  // WasUnique

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [3:0]       snoop;
    logic [2:0]       prot;
  } ac_chan_t;

  typedef struct packed {
    logic [CrW-1:0] resp;
  } cr_chan_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic             last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_chan_t cr;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter (common_cells interface). MODE=0 counts trailing zeros.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 32'd1) ? $clog2(WIDTH) : 32'd1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Both modes reduce to "last set bit visited wins, count = WIDTH-1-i";
  // only the visiting order differs.
  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (MODE) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end else begin
        if (in_i[WIDTH-1-i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/snoop_bcast.sv
// Broadcasts one upstream snoop to all master ports, ORs their CR replies and forwards one CD
// stream. Define SNOOP_BCAST_EXCL_EN to add the per-port excl_i exclusion input.
module snoop_bcast #(
  parameter type         snoop_req_t  = ace_pkg::snoop_req_t,
  parameter type         snoop_resp_t = ace_pkg::snoop_resp_t,
  parameter type         ac_chan_t    = ace_pkg::ac_chan_t,
  parameter type         cr_chan_t    = ace_pkg::cr_chan_t,
  parameter type         cd_chan_t    = ace_pkg::cd_chan_t,
  parameter int unsigned NoMstPorts   = 32'd2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef SNOOP_BCAST_EXCL_EN
  input  logic [NoMstPorts-1:0] excl_i,
`endif
  input  snoop_req_t            slv_req_i,
  output snoop_resp_t           slv_resp_o,
  output snoop_req_t            mst_reqs_o  [NoMstPorts],
  input  snoop_resp_t           mst_resps_i [NoMstPorts]
);
  import ace_pkg::*;

  typedef enum logic [2:0] {IDLE, FORK, COLLECT, RESP, DATA} state_e;

  localparam int unsigned IdxW = (NoMstPorts > 32'd1) ? $clog2(NoMstPorts) : 32'd1;

  state_e                state_q, state_d;
  ac_chan_t              ac_q, ac_d;
  logic [NoMstPorts-1:0] acc_mask_q, acc_mask_d, cr_mask_q, cr_mask_d, done_q, done_d;
  cr_chan_t              cr_q [NoMstPorts];
  cr_chan_t              cr_d [NoMstPorts];
  cr_chan_t              cr_merged;
  cd_chan_t              cd_sel;
  logic [NoMstPorts-1:0] excl, dt, ac_hs, cr_hs, cd_last_hs;
  logic [IdxW-1:0]       sel;
  logic                  dt_empty;

`ifdef SNOOP_BCAST_EXCL_EN
  assign excl = excl_i;
`else
  assign excl = '0;
`endif

  always_comb begin
    cr_merged = '0;
    dt        = '0;
    for (int unsigned i = 0; i < NoMstPorts; i++) begin
      cr_merged.resp = cr_merged.resp | cr_q[i].resp;
      dt[i]          = cr_q[i].resp[CR_DT];
    end
  end

  lzc #(
    .WIDTH     (NoMstPorts),
    .MODE      (1'b0),
    .CNT_WIDTH (IdxW)
  ) i_sel_lzc (
    .in_i    (dt),
    .cnt_o   (sel),
    .empty_o (dt_empty)
  );

  assign cd_sel = mst_resps_i[sel].cd;

  always_comb begin
    slv_resp_o = '0;
    for (int unsigned i = 0; i < NoMstPorts; i++) mst_reqs_o[i] = '0;
    unique case (state_q)
      IDLE: slv_resp_o.ac_ready = 1'b1;
      // CR is accepted while FORK is still waiting on slow AC ports.
      FORK, COLLECT: begin
        for (int unsigned i = 0; i < NoMstPorts; i++) begin
          mst_reqs_o[i].ac_valid = (state_q == FORK) && !acc_mask_q[i];
          if (mst_reqs_o[i].ac_valid) mst_reqs_o[i].ac = ac_q;
          mst_reqs_o[i].cr_ready = !cr_mask_q[i];
        end
      end
      RESP: begin
        slv_resp_o.cr_valid = 1'b1;
        slv_resp_o.cr       = cr_merged;
      end
      DATA: begin
        for (int unsigned i = 0; i < NoMstPorts; i++) begin
          if (dt[i] && !done_q[i]) begin
            mst_reqs_o[i].cd_ready = (IdxW'(i) == sel) ? slv_req_i.cd_ready : 1'b1;
          end
        end
        if (!dt_empty && !done_q[sel]) begin
          slv_resp_o.cd_valid = mst_resps_i[sel].cd_valid;
          slv_resp_o.cd       = cd_sel;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ac_hs      = '0;
    cr_hs      = '0;
    cd_last_hs = '0;
    for (int unsigned i = 0; i < NoMstPorts; i++) begin
      ac_hs[i]      = mst_reqs_o[i].ac_valid & mst_resps_i[i].ac_ready;
      cr_hs[i]      = mst_reqs_o[i].cr_ready & mst_resps_i[i].cr_valid;
      cd_last_hs[i] = mst_reqs_o[i].cd_ready & mst_resps_i[i].cd_valid & mst_resps_i[i].cd.last;
    end
  end

  always_comb begin
    state_d    = state_q;
    ac_d       = ac_q;
    acc_mask_d = acc_mask_q | ac_hs;
    cr_mask_d  = cr_mask_q | cr_hs;
    done_d     = done_q | cd_last_hs;
    cr_d       = cr_q;
    for (int unsigned i = 0; i < NoMstPorts; i++) begin
      if (cr_hs[i]) cr_d[i] = mst_resps_i[i].cr;
    end
    unique case (state_q)
      IDLE: begin
        if (slv_req_i.ac_valid) begin
          state_d    = FORK;
          ac_d       = slv_req_i.ac;
          acc_mask_d = excl;
          cr_mask_d  = excl;
          done_d     = '0;
          for (int unsigned i = 0; i < NoMstPorts; i++) cr_d[i] = '0;
        end
      end
      FORK:    if (&acc_mask_d) state_d = COLLECT;
      COLLECT: if (&cr_mask_d) state_d = RESP;
      RESP: begin
        if (slv_req_i.cr_ready) state_d = cr_merged.resp[CR_DT] ? DATA : IDLE;
      end
      DATA:    if ((done_d & dt) == dt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ac_q       <= '0;
      acc_mask_q <= '0;
      cr_mask_q  <= '0;
      done_q     <= '0;
      cr_q       <= '{default: '0};
    end else begin
      state_q    <= state_d;
      ac_q       <= ac_d;
      acc_mask_q <= acc_mask_d;
      cr_mask_q  <= cr_mask_d;
      done_q     <= done_d;
      cr_q       <= cr_d;
    end
  end

endmodule

// File: tb/tb_snoop_bcast.sv
// Self-checking bench for snoop_bcast: behavioural port models, OR/lowest-index reference model.
module tb_snoop_bcast;
  import ace_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  snoop_req_t  slv_req;
  snoop_resp_t slv_resp;
  snoop_req_t  mst_reqs  [N];
  snoop_resp_t mst_resps [N];
  logic [N-1:0] excl;

  int checks = 0;
  int errors = 0;

  int unsigned      ac_dly [N];
  int unsigned      cr_dly [N];
  logic [CrW-1:0]   cr_val [N];
  logic [DataW-1:0] beat_data [N][MAXB];
  int unsigned      nbeats;
  bit               stall;
  int unsigned      abort_at;
  int               ac_hs_cyc [N];
  int               cr_first_cyc;

  always #5 clk = ~clk;

  snoop_bcast #(
    .NoMstPorts (N)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
`ifdef SNOOP_BCAST_EXCL_EN
    .excl_i      (excl),
`endif
    .slv_req_i   (slv_req),
    .slv_resp_o  (slv_resp),
    .mst_reqs_o  (mst_reqs),
    .mst_resps_i (mst_resps)
  );

  function automatic logic [3*N+1:0] busy_flags();
    logic [3*N+1:0] f;
    f[1:0] = {slv_resp.cr_valid, slv_resp.cd_valid};
    for (int i = 0; i < N; i++)
      f[2+3*i +: 3] = {mst_reqs[i].ac_valid, mst_reqs[i].cr_ready, mst_reqs[i].cd_ready};
    return f;
  endfunction

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      ac_dly[i] = 0; cr_dly[i] = 0; cr_val[i] = '0; ac_hs_cyc[i] = -1;
    end
    excl = '0; stall = 1'b0; abort_at = 0; nbeats = 1; cr_first_cyc = -1;
  endtask

  // Runs one snoop end to end; port models follow cfg arrays, expectations come from the rules.
  task automatic do_snoop();
    ac_chan_t       ac_exp;
    logic [CrW-1:0] cr_exp;
    logic [N-1:0]   dtp;
    int             sel;
    int unsigned    ac_seen [N];
    int unsigned    cd_idx [N];
    bit             cr_sent [N];
    bit             got_cr, finished, aborted, all_done, prev_cr_stall, prev_cd_stall;
    cr_chan_t       prev_cr;
    cd_chan_t       prev_cd;
    cd_chan_t       rx [$];
    int unsigned    cyc;

    cr_exp = '0; dtp = '0; sel = -1;
    for (int i = 0; i < N; i++) begin
      if (!excl[i]) begin
        cr_exp = cr_exp | cr_val[i];
        dtp[i] = cr_val[i][CR_DT];
      end
      ac_seen[i] = 0; cd_idx[i] = 0; cr_sent[i] = 1'b0;
      for (int b = 0; b < MAXB; b++) beat_data[i][b] = $urandom;
    end
    for (int i = N - 1; i >= 0; i--) if (dtp[i]) sel = i;
    ac_exp.addr = $urandom; ac_exp.snoop = 4'($urandom); ac_exp.prot = 3'($urandom);
    got_cr = 0; finished = 0; aborted = 0; prev_cr_stall = 0; prev_cd_stall = 0;
    prev_cr = '0; prev_cd = '0;

    @(posedge clk); #1;
    slv_req.ac_valid = 1'b1;
    slv_req.ac       = ac_exp;
    #1;
    checks++;
    if (slv_resp.ac_ready !== 1'b1) begin
      errors++; $display("FAIL ac_accept: got %0b expected 1", slv_resp.ac_ready);
    end
    @(posedge clk); #1;
    slv_req.ac_valid = 1'b0;
    slv_req.ac       = '0;
    cyc = 0;

    while (!finished && !aborted && cyc < 400) begin
      for (int i = 0; i < N; i++) begin
        mst_resps[i].ac_ready = (cyc >= ac_dly[i]);
        mst_resps[i].cr_valid = (excl[i] || ac_seen[i] > 0) && !cr_sent[i] && (cyc >= cr_dly[i]);
        mst_resps[i].cr.resp  = cr_val[i];
        mst_resps[i].cd_valid = 1'b0;
        mst_resps[i].cd       = '0;
        if (cr_sent[i] && cr_val[i][CR_DT] && cd_idx[i] < nbeats) begin
          mst_resps[i].cd_valid = 1'b1;
          mst_resps[i].cd.data  = beat_data[i][cd_idx[i]];
          mst_resps[i].cd.last  = (cd_idx[i] == nbeats - 1);
        end
      end
      slv_req.cr_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      slv_req.cd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
        if (cyc == 0 && !excl[i]) begin
          checks++;
          if (mst_reqs[i].ac_valid !== 1'b1) begin
            errors++; $display("FAIL ac_latency port%0d: got %0b expected 1", i, mst_reqs[i].ac_valid);
          end
        end
        if (excl[i]) begin
          checks++;
          if ({mst_reqs[i].ac_valid, mst_reqs[i].cr_ready, mst_reqs[i].cd_ready} !== 3'b000) begin
            errors++; $display("FAIL excl_quiet port%0d: got %0b expected 000", i,
                               {mst_reqs[i].ac_valid, mst_reqs[i].cr_ready, mst_reqs[i].cd_ready});
          end
        end
        if (mst_reqs[i].ac_valid) begin
          checks++;
          if (ac_seen[i] != 0 || mst_reqs[i].ac !== ac_exp) begin
            errors++; $display("FAIL ac_issue port%0d: got ac %0h seen %0d expected ac %0h seen 0",
                               i, mst_reqs[i].ac, ac_seen[i], ac_exp);
          end
          if (mst_resps[i].ac_ready) begin ac_seen[i]++; ac_hs_cyc[i] = int'(cyc); end
        end
        if (mst_reqs[i].cr_ready && mst_resps[i].cr_valid) cr_sent[i] = 1'b1;
        if (!dtp[i]) begin
          checks++;
          if (mst_reqs[i].cd_ready !== 1'b0) begin
            errors++; $display("FAIL cd_ready_nodt port%0d: got %0b expected 0", i, mst_reqs[i].cd_ready);
          end
        end
        if (mst_resps[i].cd_valid && mst_reqs[i].cd_ready) cd_idx[i]++;
      end
      if (prev_cd_stall) begin
        checks++;
        if (slv_resp.cd_valid !== 1'b1 || slv_resp.cd !== prev_cd) begin
          errors++; $display("FAIL cd_hold: got v%0b %0h expected v1 %0h", slv_resp.cd_valid, slv_resp.cd, prev_cd);
        end
      end
      if (slv_resp.cd_valid) begin
        checks++;
        if (!got_cr) begin
          errors++; $display("FAIL cd_early: got cd_valid 1 expected 0 before CR");
        end
        if (slv_req.cd_ready) rx.push_back(slv_resp.cd);
      end
      prev_cd_stall = slv_resp.cd_valid && !slv_req.cd_ready;
      prev_cd       = slv_resp.cd;
      if (prev_cr_stall) begin
        checks++;
        if (slv_resp.cr_valid !== 1'b1 || slv_resp.cr !== prev_cr) begin
          errors++; $display("FAIL cr_hold: got v%0b %0h expected v1 %0h", slv_resp.cr_valid, slv_resp.cr, prev_cr);
        end
      end
      if (slv_resp.cr_valid) begin
        checks++;
        if (cr_first_cyc < 0) cr_first_cyc = int'(cyc);
        if (got_cr || slv_resp.cr.resp !== cr_exp) begin
          errors++; $display("FAIL cr_merge: got %0h (dup %0b) expected %0h", slv_resp.cr.resp, got_cr, cr_exp);
        end
        if (slv_req.cr_ready) got_cr = 1'b1;
      end
      prev_cr_stall = slv_resp.cr_valid && !slv_req.cr_ready;
      prev_cr       = slv_resp.cr;
      all_done = 1'b1;
      for (int i = 0; i < N; i++) if (dtp[i] && cd_idx[i] != nbeats) all_done = 1'b0;
      finished = got_cr && all_done;
      if (abort_at != 0 && rx.size() == abort_at) aborted = 1'b1;
      if (!aborted) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (aborted) return;

    for (int i = 0; i < N; i++) mst_resps[i] = '0;
    slv_req.cr_ready = 1'b0;
    slv_req.cd_ready = 1'b0;
    #1;
    checks++;
    if (!finished) begin
      errors++; $display("FAIL timeout: got %0d cycles expected completion", cyc);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ac_seen[i] != (excl[i] ? 0 : 1)) begin
        errors++; $display("FAIL ac_count port%0d: got %0d expected %0d", i, ac_seen[i], excl[i] ? 0 : 1);
      end
    end
    checks++;
    if (rx.size() != (sel >= 0 ? nbeats : 0)) begin
      errors++; $display("FAIL beat_count: got %0d expected %0d", rx.size(), sel >= 0 ? nbeats : 0);
    end
    if (sel >= 0) begin
      for (int b = 0; b < rx.size() && b < int'(nbeats); b++) begin
        checks++;
        if (rx[b].data !== beat_data[sel][b] || rx[b].last !== (b == int'(nbeats) - 1)) begin
          errors++; $display("FAIL beat_data %0d: got %0h/%0b expected %0h/%0b", b, rx[b].data,
                             rx[b].last, beat_data[sel][b], (b == int'(nbeats) - 1));
        end
      end
    end
    checks++;
    if (slv_resp.ac_ready !== 1'b1 || busy_flags() !== '0) begin
      errors++; $display("FAIL back_to_idle: got ac_ready %0b busy %0h expected 1 / 0",
                         slv_resp.ac_ready, busy_flags());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (slv_resp.ac_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ac_ready: got %0b expected 1", slv_resp.ac_ready);
    end
    checks++;
    if (busy_flags() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %0h expected 0", busy_flags());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_is_shared();
    clear_cfg();
    cr_val[2] = 5'h08;
    do_snoop();
  endtask

  task automatic test_late_ac();
    clear_cfg();
    ac_dly[2] = 5;
    cr_val[0] = 5'h10; cr_val[3] = 5'h02;
    do_snoop();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ac_hs_cyc[i] != (i == 2 ? 5 : 0)) begin
        errors++; $display("FAIL late_ac_cycle port%0d: got %0d expected %0d", i, ac_hs_cyc[i], i == 2 ? 5 : 0);
      end
    end
  endtask

  task automatic test_data_select();
    clear_cfg();
    cr_val[1] = 5'h05; cr_val[3] = 5'h05; cr_dly[3] = 2;
    nbeats = 4;
    do_snoop();
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 25; t++) begin
      clear_cfg();
      stall  = 1'b1;
      nbeats = $urandom_range(1, MAXB);
      for (int i = 0; i < N; i++) begin
        cr_val[i] = 5'($urandom_range(0, 31));
        ac_dly[i] = $urandom_range(0, 3);
        cr_dly[i] = $urandom_range(0, 3);
      end
      do_snoop();
    end
  endtask

  task automatic test_reset_mid_data();
    clear_cfg();
    cr_val[0] = 5'h01; cr_val[2] = 5'h01;
    nbeats = 4; abort_at = 1;
    do_snoop();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (slv_resp.ac_ready !== 1'b1 || busy_flags() !== '0) begin
      errors++; $display("FAIL reset_mid_data: got ac_ready %0b busy %0h expected 1 / 0",
                         slv_resp.ac_ready, busy_flags());
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      checks++;
      if (slv_resp.cd_valid !== 1'b0) begin
        errors++; $display("FAIL reset_no_beats: got %0b expected 0", slv_resp.cd_valid);
      end
    end
    for (int i = 0; i < N; i++) mst_resps[i] = '0;
    slv_req = '0;
  endtask

`ifdef SNOOP_BCAST_EXCL_EN
  task automatic test_excl();
    clear_cfg();
    excl = 4'b0010;
    cr_val[1] = 5'h01; cr_val[0] = 5'h08;
    do_snoop();
    clear_cfg();
    excl = 4'b1111;
    for (int i = 0; i < N; i++) cr_val[i] = 5'($urandom_range(1, 31));
    do_snoop();
    checks++;
    if (cr_first_cyc != 2) begin
      errors++; $display("FAIL excl_all_timing: got %0d expected 2", cr_first_cyc);
    end
    excl = '0;
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    slv_req = '0;
    for (int i = 0; i < N; i++) mst_resps[i] = '0;
    clear_cfg();
    test_reset();
    test_is_shared();
    test_late_ac();
    test_data_select();
    test_back_to_back();
    test_reset_mid_data();
`ifdef SNOOP_BCAST_EXCL_EN
    test_excl();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
